sata_rx_dword_decoder: RTL

Receive-side dword classifier fed directly by the 16→32 elastic buffer, in the 75 MHz (SATA2) system clock domain. It turns aligned 32-bit dwords plus per-byte K/error flags into decoded primitive codes and a data-dword strobe, and removes ALIGNp. It also implements CONTp suppression by repeating the last primitive and discarding scrambled junk until the next real primitive. It keeps a saturating 8b/10b error counter for the link layer.

---
 rtl/sata_prim_pkg.sv | 72 +++++++
 rtl/sata_prim_match.sv | 27 ++
 rtl/sata_rx_dword_decoder.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/sata_prim_pkg.sv
// SATA primitive dword constants and codes, shared by the rx decoder, link layer and tx encoder.
// Only byte 0 of a primitive is a K character, so every primitive carries charisk 4'b0001.
package sata_prim_pkg;

  localparam logic [3:0] PRIM_K_MASK = 4'b0001;

  localparam logic [31:0] ALIGN_P   = 32'h7B4A4ABC;
  localparam logic [31:0] CONT_P    = 32'h9999AA7C;
  localparam logic [31:0] DMAT_P    = 32'h3636B57C;
  localparam logic [31:0] EOF_P     = 32'hD5D5B57C;
  localparam logic [31:0] HOLD_P    = 32'hD5D5AA7C;
  localparam logic [31:0] HOLDA_P   = 32'h9595AA7C;
  localparam logic [31:0] PMACK_P   = 32'h9595957C;
  localparam logic [31:0] PMNAK_P   = 32'hF5F5957C;
  localparam logic [31:0] PMREQ_P_P = 32'h1717B57C;
  localparam logic [31:0] PMREQ_S_P = 32'h7575957C;
  localparam logic [31:0] R_ERR_P   = 32'h5656B57C;
  localparam logic [31:0] R_IP_P    = 32'h5555B57C;
  localparam logic [31:0] R_OK_P    = 32'h3535B57C;
  localparam logic [31:0] R_RDY_P   = 32'h4A4A957C;
  localparam logic [31:0] SOF_P     = 32'h3737B57C;
  localparam logic [31:0] SYNC_P    = 32'hB5B5957C;
  localparam logic [31:0] WTRM_P    = 32'h5858B57C;
  localparam logic [31:0] X_RDY_P   = 32'h5757B57C;

  typedef enum logic [4:0] {
    PRIM_NONE    = 5'd0,
    PRIM_ALIGN   = 5'd1,
    PRIM_CONT    = 5'd2,
    PRIM_DMAT    = 5'd3,
    PRIM_EOF     = 5'd4,
    PRIM_HOLD    = 5'd5,
    PRIM_HOLDA   = 5'd6,
    PRIM_PMACK   = 5'd7,
    PRIM_PMNAK   = 5'd8,
    PRIM_PMREQ_P = 5'd9,
    PRIM_PMREQ_S = 5'd10,
    PRIM_R_ERR   = 5'd11,
    PRIM_R_IP    = 5'd12,
    PRIM_R_OK    = 5'd13,
    PRIM_R_RDY   = 5'd14,
    PRIM_SOF     = 5'd15,
    PRIM_SYNC    = 5'd16,
    PRIM_WTRM    = 5'd17,
    PRIM_X_RDY   = 5'd18
  } prim_code_t;

  function automatic prim_code_t prim_lookup(input logic [31:0] dw);
    case (dw)
      ALIGN_P:   return PRIM_ALIGN;
      CONT_P:    return PRIM_CONT;
      DMAT_P:    return PRIM_DMAT;
      EOF_P:     return PRIM_EOF;
      HOLD_P:    return PRIM_HOLD;
      HOLDA_P:   return PRIM_HOLDA;
      PMACK_P:   return PRIM_PMACK;
      PMNAK_P:   return PRIM_PMNAK;
      PMREQ_P_P: return PRIM_PMREQ_P;
      PMREQ_S_P: return PRIM_PMREQ_S;
      R_ERR_P:   return PRIM_R_ERR;
      R_IP_P:    return PRIM_R_IP;
      R_OK_P:    return PRIM_R_OK;
      R_RDY_P:   return PRIM_R_RDY;
      SOF_P:     return PRIM_SOF;
      SYNC_P:    return PRIM_SYNC;
      WTRM_P:    return PRIM_WTRM;
      X_RDY_P:   return PRIM_X_RDY;
      default:   return PRIM_NONE;
    endcase
  endfunction

endpackage

// File: rtl/sata_prim_match.sv
// Combinational dword classifier: primitive, payload data, or decode error.
// Zero latency; exactly one of is_prim/is_data/is_err is set per dword.
module sata_prim_match
  import sata_prim_pkg::*;
(
  input  logic [31:0] dword,
  input  logic [3:0]  charisk,
  input  logic [3:0]  notintable,
  input  logic [3:0]  disperror,
  output logic        is_prim,
  output logic [4:0]  code,
  output logic        is_data,
  output logic        is_err
);

  logic       byte_err;
  prim_code_t lookup;

  assign byte_err = |(notintable | disperror);
  assign lookup   = prim_lookup(dword);

  assign is_prim = !byte_err && (charisk == PRIM_K_MASK) && (lookup != PRIM_NONE);
  assign is_data = !byte_err && (charisk == 4'b0000);
  assign is_err  = byte_err || ((charisk != 4'b0000) && !is_prim);
  assign code    = is_prim ? lookup : PRIM_NONE;

endmodule

// File: rtl/sata_rx_dword_decoder.sv
// Rx dword decoder: primitive/data strobes, ALIGN removal, CONT suppression, saturating error count.
// Two-cycle latency (match register, then FSM/output register); no back-pressure accepted.
module sata_rx_dword_decoder
  import sata_prim_pkg::*;
#(
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     isaligned,
  input  logic [31:0]              data_in,
  input  logic [3:0]               charisk_in,
  input  logic [3:0]               notintable_in,
  input  logic [3:0]               disperror_in,
  input  logic                     err_cnt_clr,
  output logic                     prim_valid,
  output logic [4:0]               prim_code,
  output logic                     data_valid,
  output logic [31:0]              data_out,
  output logic                     dec_err,
  output logic                     in_cont,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt
);

  typedef enum logic [1:0] {ST_OFF, ST_NORMAL, ST_CONT} state_t;

  localparam logic [ERR_CNT_WIDTH-1:0] CNT_ONE = 1;

  logic        m_is_prim, m_is_data, m_is_err;
  logic [4:0]  m_code;

  logic        s1_aligned, s1_is_prim, s1_is_data, s1_is_err;
  prim_code_t  s1_code;
  logic [31:0] s1_data;

  state_t      state_q, state_d;
  prim_code_t  last_q, last_d, pc_d;
  logic        pv_d, dv_d, err_d, ic_d, live;
  logic [31:0] dout_d;

  sata_prim_match u_match (
    .dword      (data_in),
    .charisk    (charisk_in),
    .notintable (notintable_in),
    .disperror  (disperror_in),
    .is_prim    (m_is_prim),
    .code       (m_code),
    .is_data    (m_is_data),
    .is_err     (m_is_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_aligned <= 1'b0;
      s1_is_prim <= 1'b0;
      s1_is_data <= 1'b0;
      s1_is_err  <= 1'b0;
      s1_code    <= PRIM_NONE;
      s1_data    <= '0;
    end else begin
      s1_aligned <= isaligned;
      s1_is_prim <= m_is_prim;
      s1_is_data <= m_is_data;
      s1_is_err  <= m_is_err;
      s1_code    <= prim_code_t'(m_code);
      s1_data    <= data_in;
    end
  end

  // Gating with the live isaligned too drops the dword already in stage 1 on a fall.
  assign live = s1_aligned && isaligned;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    pv_d    = 1'b0;
    pc_d    = PRIM_NONE;
    dv_d    = 1'b0;
    dout_d  = data_out;
    err_d   = 1'b0;
    ic_d    = 1'b0;
    if (!live) begin
      state_d = ST_OFF;
      last_d  = PRIM_NONE;
    end else if (state_q == ST_CONT) begin
      err_d = s1_is_err;
      ic_d  = 1'b1;
      if (s1_is_prim && s1_code == PRIM_ALIGN) begin
        pv_d = 1'b0;
      end else if (s1_is_prim && s1_code != PRIM_CONT) begin
        pv_d    = 1'b1;
        pc_d    = s1_code;
        last_d  = s1_code;
        ic_d    = 1'b0;
        state_d = ST_NORMAL;
      end else begin
        pv_d = 1'b1;
        pc_d = last_q;
      end
    end else begin
      state_d = ST_NORMAL;
      err_d   = s1_is_err;
      // A CONT with nothing to repeat is passed through but never becomes last_prim.
      if (s1_is_prim && s1_code == PRIM_CONT) begin
        pv_d = 1'b1;
        if (last_q != PRIM_NONE) begin
          pc_d    = last_q;
          ic_d    = 1'b1;
          state_d = ST_CONT;
        end else begin
          pc_d = PRIM_CONT;
        end
      end else if (s1_is_prim && s1_code != PRIM_ALIGN) begin
        pv_d   = 1'b1;
        pc_d   = s1_code;
        last_d = s1_code;
      end else if (s1_is_data) begin
        dv_d   = 1'b1;
        dout_d = s1_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_OFF;
      last_q     <= PRIM_NONE;
      prim_valid <= 1'b0;
      prim_code  <= PRIM_NONE;
      data_valid <= 1'b0;
      data_out   <= '0;
      dec_err    <= 1'b0;
      in_cont    <= 1'b0;
      err_cnt    <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      prim_valid <= pv_d;
      prim_code  <= pc_d;
      data_valid <= dv_d;
      data_out   <= dout_d;
      dec_err    <= err_d;
      in_cont    <= ic_d;
      if (err_cnt_clr) begin
        err_cnt <= '0;
      end else if (err_d && err_cnt != '1) begin
        err_cnt <= err_cnt + CNT_ONE;
      end
    end
  end

endmodule
